tick_sched_ctrl: RTL and testbench
==================================

// Module: tick_sched_ctrl
// PURPOSE
//   Run-time controller for the divided-clock path. Replaces a fixed-MAX_COUNT
//   divider with a sequenced tick generator. A requester loads a divide value
//   and a tick budget over a valid/ready config port, then starts and stops it.
//   The block drives a 1-cycle clock-enable strobe (tick), a square sclk, and
//   completion status for the slow-logic blocks downstream.
// PARAMETERS
//   CNT_W        16   width of divide value and internal period counter
//   TICKS_W       8   width of tick budget and tick counter
//   DEFAULT_DIV  50   divide value loaded at reset (same meaning as cfg_div)
// PORTS
//   clk        in   1        system clock, all logic on rising edge
//   rst_n      in   1        asynchronous active-low reset
//   cfg_valid  in   1        config request
//   cfg_ready  out  1        config accepted when cfg_valid & cfg_ready
//   cfg_div    in   CNT_W    half-period divide value; 0 is clamped to 1
//   cfg_count  in   TICKS_W  tick budget; 0 = free-run
//   start      in   1        start request, 1-cycle or level
//   stop       in   1        abort request
//   tick       out  1        1-cycle enable strobe, registered
//   sclk       out  1        toggles on every tick, registered
//   busy       out  1        high while state == RUN
//   done       out  1        1-cycle pulse when the budget is exhausted
//   tick_cnt   out  TICKS_W  ticks issued since last start, wraps mod 2^TICKS_W
// BEHAVIOUR
//   Reset (async, immediate, no clock needed):
//     state=IDLE, div_reg=DEFAULT_DIV, cnt_reg=0, div_cnt=0.
//     tick=0, sclk=0, busy=0, done=0, tick_cnt=0, cfg_ready=1.
//   States:
//     IDLE: cfg_ready=1. On a config handshake, latch div_reg=max(cfg_div,1)
//       and cnt_reg=cfg_count. On start, go to RUN and clear div_cnt and
//       tick_cnt. If config and start coincide, the run uses the new values.
//       stop in IDLE is ignored.
//     RUN: cfg_ready=0 and config requests are dropped, not queued.
//       start is ignored. div_cnt increments every cycle. In a cycle with
//       div_cnt==div_reg, the next edge sets div_cnt=0, tick=1, toggles sclk
//       and increments tick_cnt.
//   Timing: with start sampled in cycle 0, the first tick is in cycle
//     div_reg+2 and then repeats every div_reg+1 cycles.
//   Budget end: if cnt_reg!=0, the tick that makes tick_cnt==cnt_reg also
//     asserts done in the same cycle. The state returns to IDLE on that edge,
//     so busy=0 in the done cycle. sclk is forced to 0 on the next edge.
//   stop in RUN: next edge goes to IDLE, clears div_cnt and sclk, sets tick=0
//     and done=0. stop wins over a coincident wrap, so no tick or done is
//     issued. tick_cnt holds its value until the next start.
//   Free-run (cnt_reg==0): never asserts done; tick_cnt wraps silently.
//   Asserting rst_n mid-run returns all outputs to their reset values at once.
//     A later start uses DEFAULT_DIV.
// TESTING
//   T1 Reset: rst_n=0 with no clock -> tick=0, sclk=0, busy=0, done=0,
//      cfg_ready=1, tick_cnt=0. Start after reset with no config
//      -> tick period 51.
//   T2 Free-run: cfg_div=3, cfg_count=0, start in cycle 0 -> busy=1 from
//      cycle 1. tick in cycles 5, 9, 13; sclk toggles there; done stays 0.
//   T3 Budget: cfg_div=1, cfg_count=2, start in cycle 0 -> tick in cycles
//      3 and 5. done=1 and busy=0 in cycle 5; tick_cnt=2; sclk=0 in cycle 6.
//   T4 Config: cfg_valid during RUN -> cfg_ready=0 and the period is unchanged.
//      cfg_div=0 in IDLE -> period 2. Config plus start in the same cycle
//      -> new value used.
//   T5 Stop on wrap: cfg_div=3, stop in cycle 4 -> no tick in cycle 5.
//      IDLE in cycle 5, sclk=0, done never pulses.
//   T6 Async reset mid-run: drop rst_n between edges -> outputs reset
//      immediately. Release and restart -> first tick in cycle 52.

Source files
------------

// File: rtl/tick_sched_ctrl.sv
// tick_sched_ctrl
//   Run-time tick generator for the divided-clock path. A requester loads a
//   half-period divide value and a tick budget over a valid/ready config port,
//   then starts and stops the sequence. The block issues a registered 1-cycle
//   clock-enable strobe (tick), a square sclk that toggles on every tick, and a
//   1-cycle done pulse when a non-zero budget is exhausted.
//
// Ports
//   clk, rst_n          system clock (rising edge), async active-low reset
//   cfg_valid/cfg_ready config handshake; only accepted while idle
//   cfg_div   [CNT_W]   half-period divide value, 0 is treated as 1
//   cfg_count [TICKS_W] tick budget, 0 = free-run
//   start, stop         run control (start may be a pulse or a level)
//   tick                1-cycle enable strobe
//   sclk                square clock, toggles on each tick
//   busy                high while running
//   done                1-cycle pulse on the tick that exhausts the budget
//   tick_cnt  [TICKS_W] ticks issued since the last start (wraps)
module tick_sched_ctrl #(
    parameter int CNT_W       = 16,
    parameter int TICKS_W     = 8,
    parameter int DEFAULT_DIV = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [TICKS_W-1:0] cfg_count,
    input  logic               start,
    input  logic               stop,
    output logic               tick,
    output logic               sclk,
    output logic               busy,
    output logic               done,
    output logic [TICKS_W-1:0] tick_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   div_reg;
    logic [CNT_W-1:0]   div_cnt;
    logic [TICKS_W-1:0] cnt_reg;
    logic [TICKS_W-1:0] tick_inc;
    logic               cfg_fire;
    logic               wrap;
    logic               fin;

    assign cfg_fire = cfg_valid & cfg_ready;
    assign tick_inc = tick_cnt + 1'b1;
    // Period counter reaches the divide value: the next edge emits a tick.
    assign wrap     = (state_q == RUN) && (div_cnt == div_reg);
    // This tick exhausts a non-zero budget; stop overrides it.
    assign fin      = wrap && !stop && (cnt_reg != '0) && (tick_inc == cnt_reg);
    assign busy     = (state_q == RUN);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- next state / ready ----------------
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (stop || fin) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg  <= CNT_W'(DEFAULT_DIV);
            cnt_reg  <= '0;
            div_cnt  <= '0;
            tick     <= 1'b0;
            sclk     <= 1'b0;
            done     <= 1'b0;
            tick_cnt <= '0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            // cfg_ready is only high in IDLE, so RUN-time requests are dropped.
            if (cfg_fire) begin
                div_reg <= (cfg_div == '0) ? CNT_W'(1) : cfg_div;
                cnt_reg <= cfg_count;
            end
            unique case (state_q)
                IDLE: begin
                    // Also parks sclk low on the edge after a done cycle.
                    sclk    <= 1'b0;
                    div_cnt <= '0;
                    if (start) tick_cnt <= '0;
                end
                RUN: begin
                    if (stop) begin
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                    end else if (wrap) begin
                        div_cnt  <= '0;
                        tick     <= 1'b1;
                        sclk     <= ~sclk;
                        tick_cnt <= tick_inc;
                        done     <= fin;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tick_sched_ctrl.sv
module tb_tick_sched_ctrl;

    logic        clk, rst_n;
    logic        cfg_valid, cfg_ready;
    logic [15:0] cfg_div;
    logic [7:0]  cfg_count;
    logic        start, stop;
    logic        tick, sclk, busy, done;
    logic [7:0]  tick_cnt;

    int n_chk = 0;
    int n_err = 0;

    tick_sched_ctrl #(.CNT_W(16), .TICKS_W(8), .DEFAULT_DIV(50)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_div(cfg_div), .cfg_count(cfg_count),
        .start(start), .stop(stop),
        .tick(tick), .sclk(sclk), .busy(busy), .done(done),
        .tick_cnt(tick_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] b(input int k);
        logic [127:0] r;
        r = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [127:0] rng(input int lo, input int hi);
        logic [127:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, ".tick"},      tick,      0);
        chk({tag, ".sclk"},      sclk,      0);
        chk({tag, ".busy"},      busy,      0);
        chk({tag, ".done"},      done,      0);
        chk({tag, ".cfg_ready"}, cfg_ready, 1);
        chk({tag, ".tick_cnt"},  tick_cnt,  0);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        cv;
        logic [15:0] dv;
        logic [7:0]  ct;
        logic        st, sp;
        logic        tk, sc, bz, dn;
        logic [7:0]  tc;
        logic        rd;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic cv, input logic [15:0] dv, input logic [7:0] ct,
                                input logic st, input logic sp, input logic tk, input logic sc,
                                input logic bz, input logic dn, input logic [7:0] tc, input logic rd);
        vec_t v;
        v.cv = cv; v.dv = dv; v.ct = ct; v.st = st; v.sp = sp;
        v.tk = tk; v.sc = sc; v.bz = bz; v.dn = dn; v.tc = tc; v.rd = rd;
        return v;
    endfunction

    // Run from the current negedge (cycle 0) and record outputs for n cycles,
    // then stop and return to idle. midc>0 issues a config request in that cycle.
    task automatic run_seq(input logic cv, input logic [15:0] dv, input logic [7:0] ct,
                           input int n, input int midc, input logic [15:0] mdiv,
                           output logic [127:0] tk, output logic [127:0] bz,
                           output logic [127:0] dn, output logic [127:0] sc,
                           output logic [127:0] rd);
        tk = '0; bz = '0; dn = '0; sc = '0; rd = '0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            tk[k] = tick; bz[k] = busy; dn[k] = done; sc[k] = sclk; rd[k] = cfg_ready;
            cfg_valid = (k == 0) ? cv : (midc != 0 && k == midc);
            cfg_div   = (k == 0) ? dv : mdiv;
            cfg_count = ct;
            start     = (k == 0);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    int         m_div, m_el;
    logic [7:0] m_cnt;
    logic       e_tick, e_sclk, e_busy, e_done;
    logic [7:0] e_tc;

    task automatic model_reset();
        m_div = 50; m_el = 0; m_cnt = 0;
        e_tick = 0; e_sclk = 0; e_busy = 0; e_done = 0; e_tc = 0;
    endtask

    // Predicts next-cycle outputs from the current inputs. Ticks occur at
    // elapsed cycles div+2 + n*(div+1) after the start cycle.
    task automatic model_step();
        logic n_tick, n_done, n_busy, n_sclk;
        n_tick = 0; n_done = 0; n_busy = e_busy; n_sclk = e_sclk;
        if (!e_busy) begin
            if (cfg_valid) begin
                m_div = (cfg_div == 0) ? 1 : int'(cfg_div);
                m_cnt = cfg_count;
            end
            n_sclk = 0;
            if (start) begin
                n_busy = 1; m_el = 1; e_tc = 0;
            end
        end else if (stop) begin
            n_busy = 0; n_sclk = 0;
        end else begin
            m_el++;
            if (m_el >= m_div + 2 && ((m_el - m_div - 2) % (m_div + 1)) == 0) begin
                n_tick = 1;
                n_sclk = !e_sclk;
                e_tc   = e_tc + 8'd1;
                if (m_cnt != 0 && e_tc == m_cnt) begin
                    n_done = 1; n_busy = 0;
                end
            end
        end
        e_tick = n_tick; e_done = n_done; e_busy = n_busy; e_sclk = n_sclk;
    endtask

    logic [127:0] tk, bz, dn, sc, rd;

    initial begin
        rst_n = 1'b0; cfg_valid = 0; cfg_div = 0; cfg_count = 0; start = 0; stop = 0;

        // T1: reset values before any clock edge
        #2;
        chk_reset("t1_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table: budget run (div 1, count 2) then stop on a wrap (div 3)
        tbl[0]  = mk(1'b1, 16'd1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        tbl[1]  = mk(1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        tbl[2]  = mk(1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        tbl[3]  = mk(1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0);
        tbl[4]  = mk(1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0);
        tbl[5]  = mk(1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1);
        tbl[6]  = mk(1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1);
        tbl[7]  = mk(1'b1, 16'd3, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1);
        tbl[8]  = mk(1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        tbl[9]  = mk(1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        tbl[10] = mk(1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        tbl[11] = mk(1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        tbl[12] = mk(1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        tbl[13] = mk(1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("vec%0d.tick", i),      tick,      tbl[i].tk);
            chk($sformatf("vec%0d.sclk", i),      sclk,      tbl[i].sc);
            chk($sformatf("vec%0d.busy", i),      busy,      tbl[i].bz);
            chk($sformatf("vec%0d.done", i),      done,      tbl[i].dn);
            chk($sformatf("vec%0d.tick_cnt", i),  tick_cnt,  tbl[i].tc);
            chk($sformatf("vec%0d.cfg_ready", i), cfg_ready, tbl[i].rd);
            cfg_valid = tbl[i].cv; cfg_div = tbl[i].dv; cfg_count = tbl[i].ct;
            start = tbl[i].st; stop = tbl[i].sp;
        end
        @(negedge clk);
        cfg_valid = 0; start = 0; stop = 0;

        // Re-reset so the next run uses the default divide value
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);

        // T1: default divide -> first tick 52, period 51
        run_seq(1'b0, 16'd0, 8'd0, 110, 0, 16'd0, tk, bz, dn, sc, rd);
        chk("t1_default_ticks", tk, b(52) | b(103));
        chk("t1_default_busy",  bz, rng(1, 109));

        // T2: free-run div 3
        run_seq(1'b1, 16'd3, 8'd0, 16, 0, 16'd0, tk, bz, dn, sc, rd);
        chk("t2_ticks", tk, b(5) | b(9) | b(13));
        chk("t2_busy",  bz, rng(1, 15));
        chk("t2_sclk",  sc, rng(5, 8) | rng(13, 15));
        chk("t2_done",  dn, 0);

        // T3: budget of 2 with div 1
        run_seq(1'b1, 16'd1, 8'd2, 8, 0, 16'd0, tk, bz, dn, sc, rd);
        chk("t3_ticks", tk, b(3) | b(5));
        chk("t3_done",  dn, b(5));
        chk("t3_busy",  bz, rng(1, 4));
        chk("t3_sclk",  sc, rng(3, 4));
        chk("t3_tick_cnt_hold", tick_cnt, 2);

        // T3 variant: odd budget leaves sclk high in the done cycle, low after
        run_seq(1'b1, 16'd1, 8'd1, 6, 0, 16'd0, tk, bz, dn, sc, rd);
        chk("t3b_done", dn, b(3));
        chk("t3b_sclk", sc, b(3));

        // T4: cfg_div = 0 behaves as 1
        run_seq(1'b1, 16'd0, 8'd0, 12, 0, 16'd0, tk, bz, dn, sc, rd);
        chk("t4_div0_ticks", tk, b(3) | b(5) | b(7) | b(9) | b(11));

        // T4: config during run is dropped
        run_seq(1'b1, 16'd3, 8'd0, 14, 2, 16'd1, tk, bz, dn, sc, rd);
        chk("t4_midcfg_ticks", tk, b(5) | b(9) | b(13));
        chk("t4_midcfg_ready", rd, b(0));

        // T6: async reset mid-run
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 6; k++) @(negedge clk);
        chk("t6_prerst_tick_cnt", tick_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("t6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(1'b0, 16'd0, 8'd0, 110, 0, 16'd0, tk, bz, dn, sc, rd);
        chk("t6_restart_ticks", tk, b(52) | b(103));

        // Randomized run against the reference model
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 2500; c++) begin
            chk($sformatf("rnd%0d.tick", c),      tick,      e_tick);
            chk($sformatf("rnd%0d.sclk", c),      sclk,      e_sclk);
            chk($sformatf("rnd%0d.busy", c),      busy,      e_busy);
            chk($sformatf("rnd%0d.done", c),      done,      e_done);
            chk($sformatf("rnd%0d.tick_cnt", c),  tick_cnt,  e_tc);
            chk($sformatf("rnd%0d.cfg_ready", c), cfg_ready, !e_busy);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_div   = 16'($urandom_range(0, 6));
            cfg_count = 8'($urandom_range(0, 4));
            start     = ($urandom_range(0, 5) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            model_step();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
